// File: rtl/mem_arbiter_if.sv
// Core-side handshake bundle for mem_arbiter: instruction-fetch port and load/store data port.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
    output if_rdata, if_valid, d_rdata, d_valid
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
    input  if_rdata, if_valid, d_rdata, d_valid
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port, 1-cycle-latency RAM between fetch and data ports.
module mem_arbiter #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_arbiter_if.slave          core,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [DEPTH_LOG2-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i,
  output logic                  busy_o
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;
  typedef enum logic {PORT_IF, PORT_D} port_t;

  state_t      state_q, state_d;
  port_t       last_gnt_q, last_gnt_d;
  port_t       gnt_port_q, gnt_port_d;
  logic        gnt_store_q, gnt_store_d;
  logic        if_valid_q, if_valid_d;
  logic        d_valid_q, d_valid_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic if_elig;
  logic d_elig;
  logic pick_d;

  // Byte-offset and out-of-range address bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{core.if_addr[31:DEPTH_LOG2+2], core.if_addr[1:0],
                              core.d_addr[31:DEPTH_LOG2+2], core.d_addr[1:0]};

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    gnt_port_d  = gnt_port_q;
    gnt_store_d = gnt_store_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;

    // A port whose completion pulse is up this cycle is not asking again yet.
    if_elig = core.if_req & ~if_valid_q;
    d_elig  = core.d_req & ~d_valid_q;
    pick_d  = d_elig & (~if_elig | (last_gnt_q == PORT_IF));

    case (state_q)
      ST_IDLE: begin
        if (rst_n && (if_elig || d_elig)) begin
          mem_en_o = 1'b1;
          state_d  = ST_WAIT;
          if (pick_d) begin
            mem_we_o    = core.d_we;
            mem_addr_o  = core.d_addr[DEPTH_LOG2+1:2];
            mem_wdata_o = core.d_wdata;
            gnt_port_d  = PORT_D;
            last_gnt_d  = PORT_D;
            gnt_store_d = core.d_we;
          end else begin
            mem_addr_o  = core.if_addr[DEPTH_LOG2+1:2];
            gnt_port_d  = PORT_IF;
            last_gnt_d  = PORT_IF;
            gnt_store_d = 1'b0;
          end
        end
      end
      ST_WAIT: begin
        state_d = ST_IDLE;
        if (gnt_port_q == PORT_IF) begin
          if_valid_d = 1'b1;
          if_rdata_d = mem_rdata_i;
        end else begin
          d_valid_d = 1'b1;
          if (!gnt_store_q) begin
            d_rdata_d = mem_rdata_i;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_gnt_q  <= PORT_D;
      gnt_port_q  <= PORT_IF;
      gnt_store_q <= 1'b0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      gnt_port_q  <= gnt_port_d;
      gnt_store_q <= gnt_store_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign core.if_valid = if_valid_q;
  assign core.d_valid  = d_valid_q;
  assign core.if_rdata = if_rdata_q;
  assign core.d_rdata  = d_rdata_q;
  assign busy_o        = (state_q == ST_WAIT);

endmodule
